// File: rtl/mdlsm_pkg.sv
// Shared types for the MDLSM batch sequencer: state encoding, default index
// width and a sizing helper for the shared cycle counter.
package mdlsm_pkg;
  localparam int DEFAULT_IDX_W = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  // Width able to hold max(a,b)-1, the largest terminal count ever loaded.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/cycle_counter.sv
// Up-counter with synchronous clear/enable; tc flags count == term.
module cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == term);
endmodule

// File: rtl/batch_sequencer.sv
// Walks file indices first..last, issuing a fixed-length start pulse per job and
// waiting (with timeout) for the core's finish level before moving on.
module batch_sequencer
  import mdlsm_pkg::*;
#(
  parameter int IDX_W          = DEFAULT_IDX_W,
  parameter int START_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [IDX_W-1:0] first_index,
  input  logic [IDX_W-1:0] last_index,
  output logic [IDX_W-1:0] file_index,
  output logic           start,
  input  logic           finish,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [IDX_W:0] job_count
);
  localparam int CW = cnt_width(START_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] START_TERM = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TOUT_TERM  = CW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [IDX_W:0]   jobs_q, jobs_d;
  logic             start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]    cnt_term;

  // One counter serves both phases; it is cleared on every state change.
  cycle_counter #(.W(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .term(cnt_term),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    jobs_d   = jobs_q;
    err_d    = err_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    cnt_term = (state_q == S_ISSUE) ? START_TERM : TOUT_TERM;
    case (state_q)
      S_IDLE: if (go) begin
        err_d  = 1'b0;
        jobs_d = '0;
        if (first_index <= last_index) begin
          state_d = S_ISSUE;
          idx_d   = first_index;
          last_d  = last_index;
          start_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cnt_tc) state_d = S_WAIT;
        else begin
          start_d = 1'b1;
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      S_WAIT: begin
        if (finish) begin
          jobs_d  = jobs_q + 1'b1;
          state_d = S_NEXT;
        end else if (cnt_tc) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_clr = 1'b0;
          cnt_en  = 1'b1;
        end
      end
      S_NEXT: begin
        // Equality test so last = all-ones terminates without wrapping.
        if (idx_q == last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
          start_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      jobs_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      jobs_q  <= jobs_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign file_index = idx_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign job_count  = jobs_q;
endmodule

// File: tb/tb_batch_sequencer.sv
// Directed + randomized checks of batch_sequencer against a rule-level model:
// per-batch expected job list, start-run lengths, gaps, done/error outcome.
module tb_batch_sequencer;
  localparam int IDX_W = 10;
  localparam int SC    = 3;
  localparam int TA    = 64;
  localparam int TB    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0, go_b = 1'b0;
  logic [IDX_W-1:0] first_idx = '0, last_idx = '0;
  logic             finish = 1'b0, finish_b = 1'b0;
  logic [IDX_W-1:0] file_index, file_index_b;
  logic             start, busy, done, error;
  logic             start_b, busy_b, done_b, error_b;
  logic [IDX_W:0]   job_count, job_count_b;

  int n_chk = 0;
  int n_fail = 0;
  int model_fi = 0;

  always #5 clk = ~clk;

  batch_sequencer #(.IDX_W(IDX_W), .START_CYCLES(SC), .TIMEOUT_CYCLES(TA)) dut (
    .clk(clk), .rst(rst), .go(go), .first_index(first_idx), .last_index(last_idx),
    .file_index(file_index), .start(start), .finish(finish), .busy(busy),
    .done(done), .error(error), .job_count(job_count)
  );

  batch_sequencer #(.IDX_W(IDX_W), .START_CYCLES(SC), .TIMEOUT_CYCLES(TB)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .first_index(first_idx), .last_index(last_idx),
    .file_index(file_index_b), .start(start_b), .finish(finish_b), .busy(busy_b),
    .done(done_b), .error(error_b), .job_count(job_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One batch on dut: model predicts jobs f..l, each with an SC-cycle start run.
  task automatic run_batch(input int f, input int l, input int dly, input bit hold,
                           input bit extra_go, input int abort_run);
    int exp_n, cyc, runs, run_len, gap, dones, first_start, done_cyc, ftimer;
    bit prev_start, saw_zero, fin_loop, aborted;
    exp_n = (f <= l) ? (l - f + 1) : 0;
    cyc = 0; runs = 0; run_len = 0; gap = 0; dones = 0; ftimer = 0;
    first_start = -1; done_cyc = -1;
    prev_start = 0; saw_zero = 0; fin_loop = 0; aborted = 0;
    @(negedge clk);
    first_idx = IDX_W'(f); last_idx = IDX_W'(l); go = 1'b1; finish = hold;
    while (!fin_loop && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) go = 1'b0;
      if (start) begin
        if (!prev_start) begin
          runs++;
          if (runs == 1) first_start = cyc;
          else chk("gap_ge2", 32'(gap >= 2), 1);
          chk("run_index", 32'(file_index), 32'(f + runs - 1));
          run_len = 0;
          ftimer = 0;
          if (!hold) finish = 1'b0;
        end
        run_len++;
        chk("index_stable", 32'(file_index), 32'(f + runs - 1));
      end else begin
        if (prev_start) begin
          chk("start_len", 32'(run_len), SC);
          gap = 0;
        end
        gap++;
      end
      if (!hold && runs > 0) begin
        ftimer++;
        if (ftimer >= dly) finish = 1'b1;
      end
      if (busy && file_index == '0) saw_zero = 1;
      if (extra_go && cyc == 5) begin
        go = 1'b1; first_idx = IDX_W'($urandom); last_idx = IDX_W'($urandom);
      end
      if (extra_go && cyc == 6) go = 1'b0;
      if (done) begin
        dones++; done_cyc = cyc; fin_loop = 1;
      end
      if (abort_run > 0 && runs == abort_run && !start && gap == 1 && !fin_loop) begin
        rst = 1'b1; finish = 1'b0;
        @(negedge clk);
        chk("abort_start", 32'(start), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_error", 32'(error), 0);
        chk("abort_index", 32'(file_index), 0);
        chk("abort_jobs", 32'(job_count), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("abort_no_done", 32'({done, busy, start}), 0);
        end
        model_fi = 0;
        aborted = 1; fin_loop = 1;
      end
      prev_start = start;
    end
    if (!fin_loop) chk("batch_bound", 0, 1);
    else if (!aborted) begin
      chk("job_runs", 32'(runs), 32'(exp_n));
      chk("done_pulses", 32'(dones), 1);
      if (exp_n > 0) chk("go_to_start", 32'(first_start), 1);
      else chk("go_to_done", 32'(done_cyc), 1);
      if (f > 0) chk("no_wrap", 32'(saw_zero), 0);
      @(negedge clk);
      chk("post_done", 32'(done), 0);
      chk("post_busy", 32'(busy), 0);
      chk("post_start", 32'(start), 0);
      chk("job_count", 32'(job_count), 32'(exp_n));
      chk("error", 32'(error), 0);
      if (exp_n > 0) model_fi = l;
      chk("file_index_hold", 32'(file_index), 32'(model_fi));
    end
  endtask

  initial begin
    int cyc, starts, dcyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'({start, start_b}), 0);
    chk("rst_busy", 32'({busy, busy_b}), 0);
    chk("rst_done", 32'({done, done_b}), 0);
    chk("rst_error", 32'({error, error_b}), 0);
    chk("rst_index", 32'(file_index), 0);
    chk("rst_jobs", 32'(job_count), 0);
    rst = 1'b0;
    @(negedge clk);

    run_batch(1, 2, 20, 0, 0, 0);
    run_batch(5, 4, 0, 0, 0, 0);
    run_batch(1023, 1023, 5, 0, 0, 0);
    run_batch(1, 3, 10, 0, 0, 2);
    run_batch(1, 3, 10, 0, 0, 0);
    run_batch(2, 4, 0, 1, 1, 0);

    // Timeout: SC start cycles, TB WAIT cycles, then done with error set.
    @(negedge clk);
    first_idx = 10'd2; last_idx = 10'd6; go_b = 1'b1; finish_b = 1'b0;
    cyc = 0; starts = 0; dcyc = -1;
    while (dcyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      go_b = 1'b0;
      if (start_b) starts++;
      if (done_b) dcyc = cyc;
    end
    chk("tout_done_cycle", 32'(dcyc), SC + TB + 1);
    chk("tout_starts", 32'(starts), SC);
    chk("tout_error", 32'(error_b), 1);
    chk("tout_jobs", 32'(job_count_b), 0);
    repeat (3) @(negedge clk);
    chk("tout_error_sticky", 32'({error_b, busy_b}), 32'h2);
    first_idx = 10'd3; last_idx = 10'd3; go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    chk("tout_error_clear", 32'(error_b), 0);
    chk("tout_reissue", 32'({start_b, file_index_b}), 32'h403);
    cyc = 0;
    while (!done_b && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("tout2_done", 32'(done_b), 1);
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      int f, l;
      f = int'($urandom_range(0, 40));
      l = f + int'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0 && f > 0) l = f - 1;
      run_batch(f, l, int'($urandom_range(0, 25)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/batch_sequencer.md
BATCH_SEQUENCER -- requirements
Module: batch_sequencer

Interface
REQ-001 SHALL have parameter IDX_W, default 10, giving the width of the file index driven to the MDLSM core.
REQ-002 SHALL have parameter START_CYCLES, default 3, giving the number of cycles start is held high per job (must be at least 1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum number of cycles to wait for finish per job (must be at least 1).
REQ-004 Port: clk  input  1  the single clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: go  input  1  request to run one batch; sampled only in IDLE.
REQ-007 Port: first_index  input  IDX_W  first file index of the batch; captured on an accepted go.
REQ-008 Port: last_index  input  IDX_W  last file index of the batch, inclusive; captured on an accepted go.
REQ-009 Port: file_index  output  IDX_W  index presented to the core; held stable from the first start cycle until finish.
REQ-010 Port: start  output  1  job start to the core.
REQ-011 Port: finish  input  1  level completion from the core.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle pulse when a batch ends.
REQ-014 Port: error  output  1  sticky timeout flag; cleared by the next accepted go or by rst.
REQ-015 Port: job_count  output  IDX_W+1  number of jobs completed in the current or last batch.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT, NEXT and DONE.
REQ-017 IDLE to ISSUE on go=1 when first_index <= last_index. On this transition it captures both indices, sets file_index=first_index, clears job_count and clears error.
REQ-018 IDLE to DONE on go=1 when first_index > last_index. job_count stays 0 and start never asserts.
REQ-019 ISSUE SHALL drive start=1 for exactly START_CYCLES consecutive cycles, then move to WAIT. finish is ignored while in ISSUE.
REQ-020 WAIT, finish=1: SHALL increment job_count and move to NEXT. This includes finish=1 on the first WAIT cycle.
REQ-021 WAIT, finish=0: SHALL increment the wait counter.
REQ-022 WAIT timeout: when the wait counter reaches TIMEOUT_CYCLES without finish, SHALL set error=1, leave job_count unchanged and move to DONE.
REQ-023 NEXT: if file_index equals the captured last index, SHALL move to DONE. Otherwise it SHALL increment file_index by 1 and move to ISSUE.
REQ-024 The end-of-batch test SHALL be an equality compare, so last_index = 2^IDX_W-1 ends cleanly with no wrap to 0.
REQ-025 DONE SHALL assert done=1 for one cycle, then move to IDLE. file_index, job_count and error hold their values in IDLE.
REQ-026 go while busy=1 SHALL be ignored. Changes to first_index or last_index after capture SHALL have no effect.
REQ-027 start SHALL be 0 in every state except ISSUE. Consecutive jobs SHALL be separated by at least 2 start-low cycles (WAIT and NEXT).
REQ-028 Latency from go to the first start=1 SHALL be 1 cycle (start is registered on the ISSUE entry edge).

Reset
REQ-029 On rst=1 at a clock edge SHALL enter IDLE with start=0, done=0, busy=0, error=0, file_index=0, job_count=0, and both internal counters at 0.
REQ-030 rst mid-batch, in any state, SHALL abort the batch with no done pulse. rst has priority over go and finish in the same cycle.

Structure
REQ-031 The state enumeration and the default IDX_W SHALL live in a shared package, mdlsm_pkg.
REQ-032 SHALL instantiate one sub-module, cycle_counter, with clear, enable and terminal-count output. It is used for both the START_CYCLES pulse and the TIMEOUT_CYCLES wait.

Verification
REQ-033 Scenario: first=1, last=2, core raises finish 20 cycles after each start -> start high 3 cycles with file_index=1, then 3 cycles with file_index=2; done pulses once; job_count=2; error=0.
REQ-034 Scenario: first=5, last=4 -> done 1 cycle after go, start never high, job_count=0.
REQ-035 Scenario: first=last=1023 -> one job only; file_index never returns to 0; job_count=1.
REQ-036 Scenario: TIMEOUT_CYCLES=8, finish held at 0 -> error=1 after 8 WAIT cycles; done pulses; job_count=0; a following go clears error.
REQ-037 Scenario: rst asserted during the WAIT state of job 2 -> next cycle in IDLE with all outputs 0 and no done pulse; a fresh go then runs the batch normally.
REQ-038 Scenario: finish held at 1 throughout, and go pulsed while busy -> each job still gets a full 3-cycle start; the extra go has no effect.
